can_tx_mailbox_arbiter: RTL and testbench

- Schedules the CAN transmit mailboxes. It tracks which mailboxes hold a pending request and picks one, either by lowest ID or by oldest request.
- Presents the chosen mailbox to the TCU through a ready/busy handshake, then resolves done, arbitration loss, error and abort per mailbox.
- Sits between the wishbone register slave (mailbox writes, MCR mode bits) and the TCU. It drives the mailbox mux select for tx_ID/tx_data.

---
 rtl/can_tx_mailbox_arbiter_if.sv | 28 ++
 rtl/can_tx_mailbox_arbiter.sv | 175 +++++++++++++++++
 tb/tb_can_tx_mailbox_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_mailbox_arbiter_if.sv
// rtl/can_tx_mailbox_arbiter_if.sv - arbiter <-> TCU frame offer/completion handshake
// master = mailbox arbiter, slave = transmit control unit.
interface can_tx_mailbox_arbiter_if;
  logic       tx_pkt_ready;
  logic [1:0] tx_sel;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_arb_loss;
  logic       tx_error;

  modport master (
    output tx_pkt_ready,
    output tx_sel,
    input  tx_busy,
    input  tx_done,
    input  tx_arb_loss,
    input  tx_error
  );

  modport slave (
    input  tx_pkt_ready,
    input  tx_sel,
    output tx_busy,
    output tx_done,
    output tx_arb_loss,
    output tx_error
  );
endinterface

// File: rtl/can_tx_mailbox_arbiter.sv
// rtl/can_tx_mailbox_arbiter.sv - CAN transmit mailbox scheduler (lowest-ID or oldest-first)
// Tracks pending requests, offers one mailbox to the TCU and resolves its outcome.
module can_tx_mailbox_arbiter #(
  parameter int NUM_MB = 3,
  parameter int ID_W   = 29
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NUM_MB-1:0]      mb_load,
  input  logic [NUM_MB-1:0]      mb_abort,
  input  logic [NUM_MB*ID_W-1:0] mb_id,
  input  logic                   prio_mode,
  input  logic                   nart,
  input  logic                   tx_enable,
  can_tx_mailbox_arbiter_if.master tcu,
  output logic [NUM_MB-1:0]      mb_pending,
  output logic [NUM_MB-1:0]      mb_rqcp,
  output logic [NUM_MB-1:0]      mb_txok,
  output logic [NUM_MB-1:0]      mb_alst
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] OFFER  = 2'd2;
  localparam logic [1:0] ACTIVE = 2'd3;

  logic [1:0]        state;
  logic [1:0]        sel;
  logic              abort_req;
  logic [NUM_MB-1:0] older [NUM_MB];

  logic [NUM_MB-1:0] sel_mask;
  logic [NUM_MB-1:0] act_mask;
  logic [NUM_MB-1:0] load_ok;
  logic [NUM_MB-1:0] abort_now;
  logic [NUM_MB-1:0] cand;
  logic              comp_done;
  logic              comp_err;
  logic              comp_loss;
  logic              comp_any;
  logic              kill;
  logic [1:0]        win;
  logic              win_valid;
  logic [ID_W-1:0]   best_id;
  logic              is_old;

  assign tcu.tx_sel       = sel;
  assign tcu.tx_pkt_ready = (state == OFFER);

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NUM_MB; i++) sel_mask[i] = (sel == 2'(i));
  end

  // The offered/active mailbox is write-protected; an abort on it while active is deferred.
  assign act_mask  = sel_mask & {NUM_MB{state == ACTIVE}};
  assign load_ok   = mb_load & ~mb_abort & ~(sel_mask & {NUM_MB{(state == OFFER) || (state == ACTIVE)}});
  assign abort_now = mb_abort & mb_pending & ~act_mask;
  assign cand      = mb_pending & ~mb_abort;

  assign comp_done = (state == ACTIVE) && tcu.tx_done;
  assign comp_err  = (state == ACTIVE) && !tcu.tx_done && tcu.tx_error;
  assign comp_loss = (state == ACTIVE) && !tcu.tx_done && !tcu.tx_error && tcu.tx_arb_loss;
  assign comp_any  = comp_done || comp_err || comp_loss;
  assign kill      = nart || abort_req || ((mb_abort & act_mask) != '0);

  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    best_id   = '0;
    is_old    = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (cand[i]) begin
        if (!prio_mode) begin
          if (!win_valid || (mb_id[i*ID_W +: ID_W] < best_id)) begin
            win       = 2'(i);
            win_valid = 1'b1;
            best_id   = mb_id[i*ID_W +: ID_W];
          end
        end else begin
          is_old = 1'b1;
          for (int j = 0; j < NUM_MB; j++)
            if ((j != i) && cand[j] && !older[i][j]) is_old = 1'b0;
          if (is_old && !win_valid) begin
            win       = 2'(i);
            win_valid = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      sel        <= '0;
      abort_req  <= 1'b0;
      mb_pending <= '0;
      mb_rqcp    <= '0;
      mb_txok    <= '0;
      mb_alst    <= '0;
      for (int i = 0; i < NUM_MB; i++) older[i] <= '0;
    end else begin
      mb_rqcp <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        if (load_ok[i]) begin
          mb_pending[i] <= 1'b1;
          mb_txok[i]    <= 1'b0;
          mb_alst[i]    <= 1'b0;
        end
        if (abort_now[i]) begin
          mb_pending[i] <= 1'b0;
          mb_txok[i]    <= 1'b0;
          mb_rqcp[i]    <= 1'b1;
        end
        if (act_mask[i]) begin
          if (comp_done) begin
            mb_pending[i] <= 1'b0;
            mb_txok[i]    <= 1'b1;
            mb_rqcp[i]    <= 1'b1;
          end else if (comp_err || comp_loss) begin
            if (comp_loss) mb_alst[i] <= 1'b1;
            if (kill) begin
              mb_pending[i] <= 1'b0;
              mb_txok[i]    <= 1'b0;
              mb_rqcp[i]    <= 1'b1;
            end
          end
        end
      end

      // Age matrix: a loaded mailbox becomes younger than everything else; among
      // simultaneous loads the lower index counts as older.
      for (int i = 0; i < NUM_MB; i++) begin
        if (load_ok[i]) begin
          for (int j = 0; j < NUM_MB; j++) begin
            if (j != i) begin
              if (load_ok[j]) begin
                older[i][j] <= (i < j);
              end else begin
                older[i][j] <= 1'b0;
                older[j][i] <= 1'b1;
              end
            end
          end
        end
      end

      if (state == ACTIVE) begin
        if (comp_any) abort_req <= 1'b0;
        else if ((mb_abort & act_mask & mb_pending) != '0) abort_req <= 1'b1;
      end else begin
        abort_req <= 1'b0;
      end

      case (state)
        IDLE:   if (tx_enable && (mb_pending != '0)) state <= SELECT;
        SELECT: begin
          if (win_valid) begin
            sel   <= win;
            state <= OFFER;
          end else begin
            state <= IDLE;
          end
        end
        OFFER: begin
          if (!tx_enable || ((mb_abort & sel_mask) != '0)) state <= IDLE;
          else if (tcu.tx_busy) state <= ACTIVE;
        end
        default: if (comp_any) state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// tb/tb_can_tx_mailbox_arbiter.sv - directed bench with a queue of expected selections
// Expected mailbox indices are queued when requests are made and popped at each offer.
module tb_can_tx_mailbox_arbiter;
  localparam int NUM_MB = 3;
  localparam int ID_W   = 29;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_MB-1:0]      mb_load;
  logic [NUM_MB-1:0]      mb_abort;
  logic [NUM_MB*ID_W-1:0] mb_id;
  logic                   prio_mode;
  logic                   nart;
  logic                   tx_enable;
  logic [NUM_MB-1:0]      mb_pending;
  logic [NUM_MB-1:0]      mb_rqcp;
  logic [NUM_MB-1:0]      mb_txok;
  logic [NUM_MB-1:0]      mb_alst;

  int checks   = 0;
  int failures = 0;
  logic [1:0] sb[$];
  logic [1:0] got;

  can_tx_mailbox_arbiter_if tcu_if ();

  can_tx_mailbox_arbiter #(.NUM_MB(NUM_MB), .ID_W(ID_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .mb_load    (mb_load),
    .mb_abort   (mb_abort),
    .mb_id      (mb_id),
    .prio_mode  (prio_mode),
    .nart       (nart),
    .tx_enable  (tx_enable),
    .tcu        (tcu_if),
    .mb_pending (mb_pending),
    .mb_rqcp    (mb_rqcp),
    .mb_txok    (mb_txok),
    .mb_alst    (mb_alst)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_sel(output logic [1:0] e);
    e = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
    check("offer_sel", 32'(tcu_if.tx_sel), 32'(e));
  endtask

  task automatic wait_offer(output logic [1:0] e);
    int n;
    n = 0;
    while (tcu_if.tx_pkt_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("offer_ready", 32'(tcu_if.tx_pkt_ready), 32'd1);
    expect_sel(e);
  endtask

  task automatic serve(input logic [1:0] e);
    tcu_if.tx_busy = 1'b1;
    step();
    check("busy_drops_ready", 32'(tcu_if.tx_pkt_ready), 32'd0);
    tcu_if.tx_busy = 1'b0;
    tcu_if.tx_done = 1'b1;
    step();
    tcu_if.tx_done = 1'b0;
    check("done_rqcp", 32'(mb_rqcp), 32'(3'b001 << e));
  endtask

  initial begin
    rst = 1'b1; mb_load = '0; mb_abort = '0; prio_mode = 1'b0; nart = 1'b0; tx_enable = 1'b0;
    mb_id = {29'h03575AC5, 29'h01575AC5, 29'h19575AC5};
    tcu_if.tx_busy = 1'b0; tcu_if.tx_done = 1'b0; tcu_if.tx_arb_loss = 1'b0; tcu_if.tx_error = 1'b0;
    step(); step();
    check("rst_ready",   32'(tcu_if.tx_pkt_ready), 32'd0);
    check("rst_sel",     32'(tcu_if.tx_sel), 32'd0);
    check("rst_pending", 32'(mb_pending), 32'd0);
    check("rst_rqcp",    32'(mb_rqcp), 32'd0);
    check("rst_txok",    32'(mb_txok), 32'd0);
    check("rst_alst",    32'(mb_alst), 32'd0);
    rst = 1'b0;
    tx_enable = 1'b1;

    // lowest-ID order
    mb_load = 3'b111; sb.push_back(2'd1); sb.push_back(2'd2); sb.push_back(2'd0);
    step();
    mb_load = '0;
    check("id_pending", 32'(mb_pending), 32'h7);
    for (int k = 0; k < 3; k++) begin
      wait_offer(got);
      serve(got);
    end
    check("id_txok",    32'(mb_txok), 32'h7);
    check("id_pending0", 32'(mb_pending), 32'h0);

    // oldest-first order
    prio_mode = 1'b1;
    sb.push_back(2'd2); sb.push_back(2'd0); sb.push_back(2'd1);
    mb_load = 3'b100; step();
    mb_load = 3'b001; step();
    mb_load = 3'b010; step();
    mb_load = '0;
    for (int k = 0; k < 3; k++) begin
      wait_offer(got);
      serve(got);
    end

    // arbitration loss, retransmit then nart
    prio_mode = 1'b0;
    mb_load = 3'b010; sb.push_back(2'd1);
    step();
    mb_load = '0;
    wait_offer(got);
    tcu_if.tx_busy = 1'b1; step();
    tcu_if.tx_busy = 1'b0; tcu_if.tx_arb_loss = 1'b1; step();
    tcu_if.tx_arb_loss = 1'b0;
    check("loss_alst",    32'(mb_alst), 32'h2);
    check("loss_pending", 32'(mb_pending), 32'h2);
    check("loss_rqcp",    32'(mb_rqcp), 32'h0);
    check("loss_ready",   32'(tcu_if.tx_pkt_ready), 32'd0);
    step();
    check("reoffer_select", 32'(tcu_if.tx_pkt_ready), 32'd0);
    step();
    sb.push_back(2'd1);
    check("reoffer_ready", 32'(tcu_if.tx_pkt_ready), 32'd1);
    expect_sel(got);
    nart = 1'b1;
    tcu_if.tx_busy = 1'b1; step();
    tcu_if.tx_busy = 1'b0; tcu_if.tx_arb_loss = 1'b1; step();
    tcu_if.tx_arb_loss = 1'b0;
    nart = 1'b0;
    check("nart_pending", 32'(mb_pending), 32'h0);
    check("nart_rqcp",    32'(mb_rqcp), 32'h2);
    check("nart_txok",    32'(mb_txok), 32'h5);
    check("nart_alst",    32'(mb_alst), 32'h2);

    // aborts while mb0 is active
    prio_mode = 1'b1;
    mb_load = 3'b101; sb.push_back(2'd0);
    step();
    mb_load = '0;
    wait_offer(got);
    tcu_if.tx_busy = 1'b1; step();
    tcu_if.tx_busy = 1'b0; mb_abort = 3'b100; step();
    check("abort2_pending", 32'(mb_pending), 32'h1);
    check("abort2_rqcp",    32'(mb_rqcp), 32'h4);
    mb_abort = 3'b001; step();
    mb_abort = '0;
    check("abort0_held",  32'(mb_pending), 32'h1);
    check("abort0_rqcp",  32'(mb_rqcp), 32'h0);
    tcu_if.tx_done = 1'b1; step();
    tcu_if.tx_done = 1'b0;
    check("abort0_done_pending", 32'(mb_pending), 32'h0);
    check("abort0_done_rqcp",    32'(mb_rqcp), 32'h1);
    check("abort0_done_txok",    32'(mb_txok), 32'h1);

    // tx_enable gating
    tx_enable = 1'b0;
    mb_load = 3'b001; step();
    mb_load = '0;
    repeat (4) step();
    check("dis_ready",   32'(tcu_if.tx_pkt_ready), 32'd0);
    check("dis_pending", 32'(mb_pending), 32'h1);
    tx_enable = 1'b1; step();
    check("en_select", 32'(tcu_if.tx_pkt_ready), 32'd0);
    step();
    sb.push_back(2'd0);
    check("en_ready", 32'(tcu_if.tx_pkt_ready), 32'd1);
    expect_sel(got);
    tx_enable = 1'b0; step();
    check("offer_dis_ready", 32'(tcu_if.tx_pkt_ready), 32'd0);
    step(); step();
    check("offer_dis_idle", 32'(tcu_if.tx_pkt_ready), 32'd0);

    // reset mid-transfer
    tx_enable = 1'b1; prio_mode = 1'b0;
    mb_load = 3'b111; sb.push_back(2'd1);
    step();
    mb_load = '0;
    wait_offer(got);
    tcu_if.tx_busy = 1'b1; step();
    tcu_if.tx_busy = 1'b0; rst = 1'b1; step();
    check("mrst_ready",   32'(tcu_if.tx_pkt_ready), 32'd0);
    check("mrst_sel",     32'(tcu_if.tx_sel), 32'd0);
    check("mrst_pending", 32'(mb_pending), 32'd0);
    check("mrst_txok",    32'(mb_txok), 32'd0);
    check("mrst_alst",    32'(mb_alst), 32'd0);
    rst = 1'b0; tcu_if.tx_done = 1'b1; step();
    tcu_if.tx_done = 1'b0;
    check("post_done_rqcp",    32'(mb_rqcp), 32'd0);
    check("post_done_txok",    32'(mb_txok), 32'd0);
    check("post_done_pending", 32'(mb_pending), 32'd0);
    step();
    check("post_done_ready", 32'(tcu_if.tx_pkt_ready), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
